// File: rtl/usb_spi_master.sv
// SPI mode-0 master framing MAX3421E register accesses: one command byte
// followed by 0..127 data bytes, write data via valid/ready, read data via strobe.
module usb_spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [4:0] reg_addr,
    input  logic       write,
    input  logic       ackstat,
    input  logic [6:0] len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] status,
    output logic       busy,
    output logic       done,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_FETCH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [6:0]    bytes_left;
    logic          wr_q;
    logic [6:0]    sh_tx;
    logic [6:0]    sh_rx;

    logic shifting, half_end, rise, fall, byte_end, last_byte, accept, handshake;

    always_comb begin
        shifting  = (state == S_CMD) || (state == S_DATA);
        half_end  = (div_cnt == DIV_LAST);
        rise      = shifting && half_end && !spi_sclk;
        fall      = shifting && half_end && spi_sclk;
        byte_end  = fall && (bit_cnt == 3'd7);
        accept    = (state == S_IDLE) && start;
        handshake = (state == S_FETCH) && tx_valid && tx_ready;
        // bytes_left holds the data-byte count still owed, including the one in flight
        last_byte = (state == S_CMD) ? (bytes_left == '0) : (bytes_left == 7'd1);
        state_nx  = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_CMD;
            S_CMD, S_DATA: begin
                if (byte_end) begin
                    if (last_byte)  state_nx = S_HOLD;
                    else if (wr_q)  state_nx = S_FETCH;
                    else            state_nx = S_DATA;
                end
            end
            S_FETCH: if (handshake) state_nx = S_DATA;
            S_HOLD:  if (half_end) state_nx = S_GAP;
            S_GAP:   if (half_end) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bytes_left <= '0;
            wr_q       <= 1'b0;
            sh_tx      <= '0;
            sh_rx      <= '0;
            tx_ready   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            status     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            if (shifting || (state == S_HOLD) || (state == S_GAP)) begin
                div_cnt <= half_end ? '0 : div_cnt + DW'(1);
            end else begin
                div_cnt <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy       <= 1'b1;
                        spi_cs_n   <= 1'b0;
                        spi_mosi   <= reg_addr[4];
                        sh_tx      <= {reg_addr[3:0], 1'b0, write, ackstat};
                        wr_q       <= write;
                        bytes_left <= len;
                        bit_cnt    <= '0;
                    end
                end
                S_CMD, S_DATA: begin
                    if (rise) begin
                        spi_sclk <= 1'b1;
                        sh_rx    <= {sh_rx[5:0], spi_miso};
                        if (bit_cnt == 3'd7) begin
                            if (state == S_CMD) begin
                                status <= {sh_rx, spi_miso};
                            end else if (!wr_q) begin
                                rx_data  <= {sh_rx, spi_miso};
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    if (fall) begin
                        spi_sclk <= 1'b0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == S_DATA) bytes_left <= bytes_left - 7'd1;
                            // read bytes chain straight on with MOSI low
                            sh_tx    <= '0;
                            spi_mosi <= 1'b0;
                            if (!last_byte && wr_q) tx_ready <= 1'b1;
                        end else begin
                            spi_mosi <= sh_tx[6];
                            sh_tx    <= {sh_tx[5:0], 1'b0};
                        end
                    end
                end
                S_FETCH: begin
                    if (handshake) begin
                        tx_ready <= 1'b0;
                        spi_mosi <= tx_data[7];
                        sh_tx    <= tx_data[6:0];
                        bit_cnt  <= '0;
                    end
                end
                S_HOLD: begin
                    if (half_end) spi_cs_n <= 1'b1;
                end
                S_GAP: begin
                    if (half_end) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_spi_master.sv
// Bench for usb_spi_master: table vectors, randomized transactions against a
// byte-level reference model, plus reset-abort and back-to-back start sequences.
module tb_usb_spi_master;
    localparam int unsigned CLK_DIV = 2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [4:0] reg_addr;
    logic       write;
    logic       ackstat;
    logic [6:0] len;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] status;
    logic       busy;
    logic       done;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned abs_cyc = 0;

    logic [7:0]  txq[$];
    logic [7:0]  misoq[$];
    int unsigned stallq[$];
    logic [4:0]  nx_addr;
    logic        nx_write;
    logic        nx_ack;
    logic [6:0]  nx_len;
    int unsigned last_fall_abs;
    int unsigned last_rise_abs;

    usb_spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (start),
        .reg_addr (reg_addr),
        .write    (write),
        .ackstat  (ackstat),
        .len      (len),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .status   (status),
        .busy     (busy),
        .done     (done),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) abs_cyc <= abs_cyc + 1;

    typedef struct {
        logic [4:0]  addr;
        logic        wr;
        logic        ak;
        int unsigned n;
        int unsigned stall;
        logic [7:0]  d0, d1, d2;
        logic [7:0]  m0, m1, m2, m3;
        logic [7:0]  exp_cmd;
        int unsigned exp_done;
        int unsigned exp_cs;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycles from the start-sampling cycle to done, from the transaction timing rules
    function automatic int unsigned model_done(input logic wr, input int unsigned n,
                                               input int unsigned stall_sum);
        return 2 + 16 * CLK_DIV * (n + 1) + 2 * CLK_DIV - 1 + (wr ? n + stall_sum : 0);
    endfunction

    function automatic logic miso_bit(input int unsigned idx);
        logic [7:0] b;
        if (idx / 8 >= misoq.size()) return 1'b0;
        b = misoq[idx / 8];
        return b[7 - (idx % 8)];
    endfunction

    task automatic run_txn(input string tag, input logic [4:0] a, input logic wr, input logic ak,
                           input int unsigned n, input bit started, input bit chain,
                           input logic [7:0] exp_cmd, input int unsigned exp_done,
                           input int unsigned exp_cs);
        logic [7:0]  mosi_got[$];
        logic [7:0]  rx_got[$];
        logic [7:0]  mb;
        logic [7:0]  exp_b;
        logic        prev_sclk, prev_cs, prev_mosi, prev_rxv;
        int unsigned cyc, cs_rise, done_cyc, hs, mbit, nbits, viol, rdy_cnt, st;
        bit          got_done;
        mb = '0; cyc = 0; cs_rise = 0; done_cyc = 0; hs = 0; mbit = 0; nbits = 0;
        viol = 0; rdy_cnt = 0; got_done = 0;
        if (!started) begin
            reg_addr = a; write = wr; ackstat = ak; len = 7'(n); start = 1'b1;
        end
        prev_sclk = spi_sclk; prev_cs = spi_cs_n; prev_mosi = spi_mosi; prev_rxv = rx_valid;
        while (!got_done && cyc < 4000) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) begin
                last_fall_abs = abs_cyc;
                chk({tag, "_busy_t1"}, 32'(busy), 32'd1);
                chk({tag, "_csn_t1"}, 32'(spi_cs_n), 32'd0);
                chk({tag, "_mosi_t1"}, 32'(spi_mosi), 32'(exp_cmd[7]));
                chk({tag, "_sclk_t1"}, 32'(spi_sclk), 32'd0);
            end
            if (prev_cs && !spi_cs_n) mbit = 0;
            if (prev_sclk && !spi_sclk) mbit++;
            if (!prev_sclk && spi_sclk) begin
                mb = {mb[6:0], spi_mosi};
                nbits++;
                if (nbits % 8 == 0) mosi_got.push_back(mb);
            end
            if (spi_sclk && (spi_mosi != prev_mosi)) viol++;
            if (spi_cs_n && spi_sclk) viol++;
            if (tx_ready && (spi_sclk || spi_cs_n)) viol++;
            if (rx_valid && prev_rxv) viol++;
            if (tx_ready && rx_valid) viol++;
            if (rx_valid) rx_got.push_back(rx_data);
            if (spi_cs_n && !prev_cs) begin
                cs_rise = cyc;
                last_rise_abs = abs_cyc;
            end
            st = (hs < stallq.size()) ? stallq[hs] : 0;
            if (tx_ready) begin
                if (rdy_cnt >= st) begin
                    tx_valid = 1'b1;
                    tx_data  = (hs < txq.size()) ? txq[hs] : 8'h00;
                    hs++;
                    rdy_cnt = 0;
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                    rdy_cnt++;
                end
            end else begin
                rdy_cnt  = 0;
                tx_valid = wr && (st == 0);
                tx_data  = (hs < txq.size()) ? txq[hs] : 8'($urandom);
            end
            start    = busy && ($urandom_range(0, 5) == 0);
            reg_addr = 5'($urandom);
            write    = 1'($urandom);
            ackstat  = 1'($urandom);
            len      = 7'($urandom);
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                if (chain) begin
                    start = 1'b1; reg_addr = nx_addr; write = nx_write;
                    ackstat = nx_ack; len = nx_len;
                end
            end
            spi_miso  = miso_bit(mbit);
            prev_sclk = spi_sclk; prev_cs = spi_cs_n; prev_mosi = spi_mosi; prev_rxv = rx_valid;
        end
        if (!chain) start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_csn_rise_cycle"}, cs_rise, exp_cs);
        chk({tag, "_mosi_bytes"}, mosi_got.size(), n + 1);
        for (int i = 0; i < mosi_got.size() && i <= n; i++) begin
            if (i == 0) exp_b = exp_cmd;
            else exp_b = (wr && (i - 1 < txq.size())) ? txq[i - 1] : 8'h00;
            chk($sformatf("%s_mosi_byte%0d", tag, i), 32'(mosi_got[i]), 32'(exp_b));
        end
        chk({tag, "_status"}, 32'(status), 32'(misoq[0]));
        chk({tag, "_rx_count"}, rx_got.size(), wr ? 0 : n);
        for (int i = 0; i < rx_got.size() && i < n; i++) begin
            chk($sformatf("%s_rx_byte%0d", tag, i), 32'(rx_got[i]), 32'(misoq[i + 1]));
        end
        chk({tag, "_handshakes"}, hs, wr ? n : 0);
        chk({tag, "_protocol"}, viol, 0);
    endtask

    task automatic load_vec(input int unsigned i);
        txq    = '{vecs[i].d0, vecs[i].d1, vecs[i].d2};
        misoq  = '{vecs[i].m0, vecs[i].m1, vecs[i].m2, vecs[i].m3};
        stallq = '{vecs[i].stall, vecs[i].stall, vecs[i].stall};
    endtask

    task automatic idle(input int unsigned k);
        repeat (k) begin
            @(negedge Clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int unsigned n, ssum, ed;
        logic [4:0]  a;
        logic        wr, ak;
        logic [31:0] rnd;
        string       tag;

        vecs[0] = '{5'h11, 1'b1, 1'b0, 1, 0,  8'h20, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h8A, 70, 68};
        vecs[1] = '{5'h13, 1'b0, 1'b0, 2, 0,  8'h00, 8'h00, 8'h00, 8'h5A, 8'hC3, 8'h3C, 8'h00, 8'h98, 101, 99};
        vecs[2] = '{5'h05, 1'b1, 1'b0, 1, 10, 8'hA5, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 8'h00, 8'h2A, 80, 78};
        vecs[3] = '{5'h11, 1'b1, 1'b1, 0, 0,  8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h8B, 37, 35};
        vecs[4] = '{5'h1F, 1'b0, 1'b1, 0, 0,  8'h00, 8'h00, 8'h00, 8'hE7, 8'h00, 8'h00, 8'h00, 8'hF9, 37, 35};
        vecs[5] = '{5'h0A, 1'b1, 1'b1, 3, 0,  8'h01, 8'h80, 8'hFF, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h53, 136, 134};
        vecs[6] = '{5'h00, 1'b0, 1'b0, 1, 0,  8'h00, 8'h00, 8'h00, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 69, 67};
        vecs[7] = '{5'h1C, 1'b1, 1'b0, 2, 1,  8'h3C, 8'hC3, 8'h00, 8'h96, 8'h00, 8'h00, 8'h00, 8'hE2, 105, 103};

        Reset = 1'b1; start = 1'b0; reg_addr = '0; write = 1'b0; ackstat = 1'b0; len = '0;
        tx_data = '0; tx_valid = 1'b0; spi_miso = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_csn", 32'(spi_cs_n), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sclk", 32'(spi_sclk), 32'd0);
        Reset = 1'b0;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            load_vec(i);
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].ak, vecs[i].n,
                    0, 0, vecs[i].exp_cmd, vecs[i].exp_done, vecs[i].exp_cs);
            idle(1 + $urandom_range(0, 3));
        end

        // Reset in the middle of the first read data byte
        misoq = '{8'h5A, 8'hC3, 8'h3C};
        reg_addr = 5'h13; write = 1'b0; ackstat = 1'b0; len = 7'd2; start = 1'b1; spi_miso = 1'b1;
        repeat (50) begin
            @(negedge Clk);
            start = 1'b0;
        end
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        chk("midrst_pre_status", 32'(status), 32'hFF);
        Reset = 1'b1;
        #1;
        chk("midrst_csn", 32'(spi_cs_n), 32'd1);
        chk("midrst_sclk", 32'(spi_sclk), 32'd0);
        chk("midrst_mosi", 32'(spi_mosi), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_txready", 32'(tx_ready), 32'd0);
        chk("midrst_rxvalid", 32'(rx_valid), 32'd0);
        chk("midrst_rxdata", 32'(rx_data), 32'd0);
        chk("midrst_status", 32'(status), 32'd0);
        repeat (3) @(negedge Clk);
        chk("midrst_hold_done", 32'(done), 32'd0);
        chk("midrst_hold_csn", 32'(spi_cs_n), 32'd1);
        Reset = 1'b0; spi_miso = 1'b0;
        idle(1);
        load_vec(1);
        run_txn("after_reset", vecs[1].addr, vecs[1].wr, vecs[1].ak, vecs[1].n,
                0, 0, vecs[1].exp_cmd, vecs[1].exp_done, vecs[1].exp_cs);
        idle(2);

        // Start on the done cycle chains straight into the next transaction
        nx_addr = 5'h11; nx_write = 1'b1; nx_ack = 1'b1; nx_len = 7'd0;
        load_vec(6);
        run_txn("chain_a", vecs[6].addr, vecs[6].wr, vecs[6].ak, vecs[6].n,
                0, 1, vecs[6].exp_cmd, vecs[6].exp_done, vecs[6].exp_cs);
        ed = last_rise_abs;
        load_vec(3);
        run_txn("chain_b", vecs[3].addr, vecs[3].wr, vecs[3].ak, vecs[3].n,
                1, 0, vecs[3].exp_cmd, vecs[3].exp_done, vecs[3].exp_cs);
        chk("chain_csn_high_cycles", last_fall_abs - ed, CLK_DIV + 1);
        idle(2);

        for (int t = 0; t < 25; t++) begin
            a  = 5'($urandom);
            wr = 1'($urandom);
            ak = 1'($urandom);
            n  = $urandom_range(0, 5);
            txq = {}; misoq = {}; stallq = {};
            ssum = 0;
            for (int k = 0; k < n; k++) begin
                rnd = $urandom;
                txq.push_back(rnd[7:0]);
                stallq.push_back($urandom_range(0, 3));
                ssum += stallq[k];
            end
            for (int k = 0; k <= n; k++) begin
                rnd = $urandom;
                misoq.push_back(rnd[7:0]);
            end
            ed  = model_done(wr, n, ssum);
            tag = $sformatf("rnd%0d", t);
            run_txn(tag, a, wr, ak, n, 0, 0, {a, 1'b0, wr, ak}, ed, ed - CLK_DIV);
            idle($urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_spi_master.md
# usb_spi_master

SPI master that runs register transactions to the MAX3421E USB host controller on the Arduino header (`SPI0_CS_N`/`SPI0_SCLK`/`SPI0_MOSI`/`SPI0_MISO`). It sits between the USB host-control logic and the top-level pins. It frames each access as one MAX3421E command byte followed by 0..127 data bytes. Write data arrives on a valid/ready stream; read data leaves as a one-cycle-strobe stream.

## Interface
- `CLK_DIV`, 2: system clocks per SCLK half-period. Minimum 2, which gives 12.5 MHz at 50 MHz.
- `Clk` input 1: system clock (`MAX10_CLK1_50`).
- `Reset` input 1: asynchronous, active-high.
- `start` input 1: request a transaction. Sampled only when `busy`=0.
- `reg_addr` input 5: MAX3421E register number.
- `write` input 1: 1 = write, 0 = read.
- `ackstat` input 1: ACKSTAT bit of the command byte.
- `len` input 7: number of data bytes after the command byte (0..127).
- `tx_data` input 8: write byte.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: block is accepting a write byte.
- `rx_data` output 8: last received data byte.
- `rx_valid` output 1: one-cycle strobe; `rx_data` is new.
- `status` output 8: byte shifted in during the command byte (HIRQ).
- `busy` output 1: a transaction is in progress.
- `done` output 1: one-cycle pulse at transaction end.
- `spi_cs_n`, `spi_sclk`, `spi_mosi` output 1 each.
- `spi_miso` input 1.

## Operation
- SPI mode 0, MSB first. SCLK idles low. MOSI changes only while SCLK is low. MISO is sampled on the system clock edge where `spi_sclk` goes 0→1.
- Command byte: `{reg_addr, 1'b0, write, ackstat}`.
- On `start` with `busy`=0, latch all request inputs. Later changes to them have no effect.
- States and transitions:
  - IDLE → CMD.
  - CMD → DATA, or → HOLD if `len`=0.
  - DATA → FETCH between write bytes.
  - DATA → DATA between read bytes.
  - Last byte → HOLD → GAP → IDLE.
- FETCH (write only):
  - `tx_ready`=1, SCLK low, CS low. The block stalls indefinitely.
  - Handshake is `tx_valid && tx_ready`. The byte loads into the shifter and `tx_ready` drops on the next cycle.
- Read data bytes: MOSI is driven 0. After the 8th rising-edge sample, `rx_data` updates and `rx_valid` pulses the following cycle. There is no backpressure; the consumer must take it.
- `status` updates once, after the command byte's 8th sample, and holds until the next command byte completes.
- `tx_ready` and `rx_valid` are never high in the same transaction.
- `start` while `busy`=1 is ignored. No queuing.
- `len` is counted by a 7-bit down-counter. There is no clamp: the MAX3421E 64-byte FIFO limit is the caller's responsibility.
- Reset (asynchronous) forces:
  - `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0.
  - `busy`=0, `done`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0x00, `status`=0x00.
  - State = IDLE.
  - Reset mid-transaction aborts at once. No partial byte completes and no `done` pulse is issued.
- All outputs are registered.

## Timing
- `start` sampled at cycle T:
  - At T+1: `busy`=1, `spi_cs_n`=0, `spi_mosi`=cmd[7], `spi_sclk`=0.
- Each bit is CLK_DIV cycles low, then CLK_DIV cycles high.
  - The k-th rise (k=1..8) is at S+(2k−1)·CLK_DIV.
  - The k-th fall is at S+2k·CLK_DIV.
  - S is the byte start cycle; for the command byte S=T+1.
- Read byte chaining: the next byte's S is the previous byte's 8th fall. Its bit 7 is driven on that cycle, so there is no gap.
- Write byte chaining:
  - `tx_ready`=1 from the previous byte's 8th fall.
  - A handshake at cycle H gives S=H+1.
  - Zero-wait writes therefore add 1 cycle per byte.
- Final 8th fall F:
  - `spi_cs_n`=1 at F+CLK_DIV.
  - `done`=1 and `busy`=0 at F+2·CLK_DIV.
  - `start` is accepted on that same cycle.
- Total duration:
  - Read: 2+16·CLK_DIV·(len+1)+2·CLK_DIV−1 cycles from T to `done`.
  - Write: the same, plus 1 per data byte, plus any stall.

## Test plan
- **Single write**, CLK_DIV=2, reg 0x11, write=1, ackstat=0, len=1, `tx_valid` held high with 0x20.
  - MOSI bytes 0x8A then 0x20.
  - `tx_ready` handshake at T+33.
  - `spi_cs_n` rises at T+68; `done` at T+70.
- **Burst read**, reg 0x13, len=2; MISO model returns 0x5A, 0xC3, 0x3C.
  - MOSI cmd 0x98, then 0x00.
  - `status`=0x5A.
  - `rx_valid` pulses twice, carrying 0xC3 then 0x3C.
  - `done` once.
- **Write stall**: `tx_valid` low for 10 cycles after `tx_ready` rises.
  - No SCLK edges; `spi_cs_n` stays 0.
  - Data bits begin the cycle after the handshake.
  - Byte value intact.
- **Command only**: len=0, reg 0x11, write=1, ackstat=1.
  - MOSI 0x8B.
  - `spi_cs_n` high at T+35; `done` at T+37.
  - No `tx_ready` / `rx_valid`.
- **Reset mid-byte** during a read data byte.
  - All outputs return to reset values immediately; no `done`.
  - A subsequent transaction completes correctly.
- **Start handling**: `start` pulsed while `busy`=1, then `start` asserted on the `done` cycle.
  - The first is ignored.
  - The second is accepted, with `spi_cs_n` high for exactly CLK_DIV+1 cycles between transactions.
